// File: rtl/vga_fb_line_sched.sv
// Shares one single-port framebuffer RAM between per-scanline row fills
// (done in hblank into a line buffer) and game-logic pixel writes.
`timescale 1ns/1ps
module vga_fb_line_sched #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int AW     = 15,
  parameter int H_VIS  = 640,
  parameter int V_VIS  = 480,
  parameter int V_LAST = 525
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   hcount,
  input  logic [10:0]   vcount,
  output logic [11:0]   pix_rgb,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_x,
  input  logic [6:0]    wr_y,
  input  logic [11:0]   wr_data,
  output logic          wr_drop,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [11:0]   mem_wdata,
  input  logic [11:0]   mem_rdata,
  output logic          fill_busy
);

  localparam logic [10:0] HVis  = 11'(H_VIS);
  localparam logic [10:0] VVis  = 11'(V_VIS);
  localparam logic [10:0] VLast = 11'(V_LAST);
  localparam logic [7:0]  FbW   = 8'(FB_W);
  localparam logic [6:0]  FbH   = 7'(FB_H);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

  state_t        state_q, state_d;
  logic          hAtVis_q;
  logic          pend_q, pend_d;
  logic [AW-1:0] pendBase_q, pendBase_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [11:0]   mem_wdata_q, mem_wdata_d;
  logic          wr_drop_q, wr_drop_d;
  logic          fill_busy_q, fill_busy_d;
  logic [11:0]   pix_q;
  logic [11:0]   linebuf [FB_W];

  logic          hAtVis, trigger, validTrig, inRange;
  logic [10:0]   nextLine;
  logic [AW-1:0] trigBase, wrAddr;

  // Row-major address: y*160 built from shifts so no multiplier is needed.
  function automatic logic [AW-1:0] rowBase(input logic [6:0] r);
    logic [AW-1:0] rr;
    rr = AW'(r);
    return (rr << 7) + (rr << 5);
  endfunction

  assign hAtVis    = (hcount == HVis);
  assign trigger   = hAtVis && !hAtVis_q;
  assign nextLine  = (vcount == VLast) ? 11'd0 : vcount + 11'd1;
  assign validTrig = trigger && (nextLine < VVis);
  assign trigBase  = rowBase(nextLine[8:2]);
  assign wrAddr    = rowBase(wr_y) + AW'(wr_x);
  assign inRange   = (wr_x < FbW) && (wr_y < FbH);
  // A pending fill also blocks writes so it is served before the next write.
  assign wr_ready  = (state_q == IDLE) && !trigger && !pend_q && !rst;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pendBase_d  = pendBase_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    wr_drop_d   = 1'b0;
    fill_busy_d = fill_busy_q;
    case (state_q)
      IDLE: begin
        if (pend_q || validTrig) begin
          state_d     = FILL;
          mem_addr_d  = pend_q ? pendBase_q : trigBase;
          pend_d      = 1'b0;
          cnt_d       = 8'd0;
          fill_busy_d = 1'b1;
        end else if (wr_valid && wr_ready) begin
          state_d   = WRITE;
          mem_we_d  = inRange;
          wr_drop_d = !inRange;
          if (inRange) begin
            mem_addr_d  = wrAddr;
            mem_wdata_d = wr_data;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (validTrig) begin
          pend_d     = 1'b1;
          pendBase_d = trigBase;
        end
      end
      FILL: begin
        if (cnt_q == FbW) begin
          state_d     = IDLE;
          fill_busy_d = 1'b0;
        end else begin
          cnt_d      = cnt_q + 8'd1;
          mem_addr_d = mem_addr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hAtVis_q    <= 1'b0;
      pend_q      <= 1'b0;
      pendBase_q  <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_drop_q   <= 1'b0;
      fill_busy_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      hAtVis_q    <= hAtVis;
      pend_q      <= pend_d;
      pendBase_q  <= pendBase_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_drop_q   <= wr_drop_d;
      fill_busy_q <= fill_busy_d;
      pix_q       <= (hcount < HVis && vcount < VVis) ? linebuf[hcount[9:2]] : 12'd0;
    end
  end

  // Read data trails the issued address by one clock, hence the cnt-1 slot.
  always_ff @(posedge clk) begin
    if (!rst && state_q == FILL && cnt_q != 8'd0)
      linebuf[cnt_q - 8'd1] <= mem_rdata;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_drop   = wr_drop_q;
  assign fill_busy = fill_busy_q;
  assign pix_rgb   = pix_q;

endmodule

// File: tb/tb_vga_fb_line_sched.sv
// Directed bench for vga_fb_line_sched with a behavioural single-port RAM.
`timescale 1ns/1ps
module tb_vga_fb_line_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount, vcount;
  logic [11:0] pix_rgb;
  logic        wr_valid, wr_ready, wr_drop;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata, mem_rdata;
  logic        fill_busy;

  logic [11:0] ram [19200];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_fb_line_sched dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .pix_rgb(pix_rgb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_drop(wr_drop), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fill_busy(fill_busy)
  );

  // Synchronous-read RAM: data for an address appears one clock later.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic stepClk(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v, input logic valid,
                               input logic [7:0] x, input logic [6:0] y, input logic [11:0] d);
    hcount   = h;
    vcount   = v;
    wr_valid = valid;
    wr_x     = x;
    wr_y     = y;
    wr_data  = d;
    #1;
  endtask

  // Entered on the first fill cycle; leaves on the first cycle with fill_busy low.
  task automatic runFill(input int base, input string tag);
    int busy = 0;
    int bad  = 0;
    for (int k = 0; k < 400; k++) begin
      if (!fill_busy) break;
      if (k < 160 && (mem_addr !== 15'(base + k) || mem_we !== 1'b0)) bad++;
      if (wr_ready !== 1'b0) bad++;
      busy++;
      stepClk();
    end
    checkOutput({tag, " busy len"}, busy, 161);
    checkOutput({tag, " addr/ready errs"}, bad, 0);
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) ram[i] = 12'h000;
    for (int i = 0; i < 160; i++) begin
      ram[i]       = 12'h800 | 12'(i);
      ram[160 + i] = 12'(i);
    end

    rst = 1'b1;
    applyStimulus(11'd0, 11'd0, 1'b1, 8'd1, 7'd1, 12'h111);
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput("rst wr_ready", wr_ready, 0);
      checkOutput("rst mem_we", mem_we, 0);
      checkOutput("rst pix", pix_rgb, 0);
      checkOutput("rst fill_busy", fill_busy, 0);
    end
    rst = 1'b0;
    applyStimulus(11'd0, 11'd0, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    checkOutput("post-rst wr_ready", wr_ready, 1);
    checkOutput("post-rst mem_addr", mem_addr, 0);

    applyStimulus(11'd0, 11'd0, 1'b1, 8'd5, 7'd2, 12'hF0A);
    checkOutput("wr accept ready", wr_ready, 1);
    stepClk();
    applyStimulus(11'd0, 11'd0, 1'b0, 8'd0, 7'd0, 12'h000);
    checkOutput("wr mem_we", mem_we, 1);
    checkOutput("wr mem_addr", mem_addr, 325);
    checkOutput("wr mem_wdata", mem_wdata, 12'hF0A);
    checkOutput("wr no drop", wr_drop, 0);
    stepClk();
    checkOutput("wr we 1clk", mem_we, 0);
    checkOutput("wr ram", ram[325], 12'hF0A);

    applyStimulus(11'd0, 11'd0, 1'b1, 8'd160, 7'd0, 12'h555);
    stepClk();
    applyStimulus(11'd0, 11'd0, 1'b0, 8'd0, 7'd0, 12'h000);
    checkOutput("x oor we", mem_we, 0);
    checkOutput("x oor drop", wr_drop, 1);
    stepClk();
    checkOutput("drop 1clk", wr_drop, 0);
    applyStimulus(11'd0, 11'd0, 1'b1, 8'd0, 7'd120, 12'h555);
    stepClk();
    applyStimulus(11'd0, 11'd0, 1'b0, 8'd0, 7'd0, 12'h000);
    checkOutput("y oor we", mem_we, 0);
    checkOutput("y oor drop", wr_drop, 1);
    stepClk();

    applyStimulus(11'd639, 11'd3, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk(2);
    applyStimulus(11'd640, 11'd3, 1'b1, 8'd10, 7'd50, 12'hABC);
    checkOutput("trig blocks write", wr_ready, 0);
    stepClk();
    runFill(160, "row1");
    checkOutput("after fill ready", wr_ready, 1);
    checkOutput("after fill we", mem_we, 0);
    stepClk();
    applyStimulus(11'd640, 11'd3, 1'b0, 8'd0, 7'd0, 12'h000);
    checkOutput("stalled wr we", mem_we, 1);
    checkOutput("stalled wr addr", mem_addr, 8010);
    checkOutput("stalled wr data", mem_wdata, 12'hABC);
    stepClk();
    checkOutput("stalled wr ram", ram[8010], 12'hABC);
    checkOutput("row1 intact", ram[163], 12'h003);

    applyStimulus(11'd12, 11'd4, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    checkOutput("pix h12", pix_rgb, 12'h003);
    applyStimulus(11'd639, 11'd4, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    checkOutput("pix h639", pix_rgb, 12'h09F);
    applyStimulus(11'd700, 11'd4, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    checkOutput("pix hblank", pix_rgb, 0);
    applyStimulus(11'd12, 11'd480, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    checkOutput("pix vblank", pix_rgb, 0);

    applyStimulus(11'd639, 11'd479, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    applyStimulus(11'd640, 11'd479, 1'b0, 8'd0, 7'd0, 12'h000);
    checkOutput("v479 trig ready", wr_ready, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        stepClk();
        if (fill_busy) seen++;
      end
      checkOutput("v479 no fill", seen, 0);
    end
    checkOutput("v479 idle ready", wr_ready, 1);

    applyStimulus(11'd639, 11'd10, 1'b1, 8'd0, 7'd0, 12'h123);
    checkOutput("pend wr ready", wr_ready, 1);
    stepClk();
    applyStimulus(11'd640, 11'd10, 1'b0, 8'd0, 7'd0, 12'h000);
    checkOutput("pend wr we", mem_we, 1);
    stepClk();
    checkOutput("pend idle busy", fill_busy, 0);
    checkOutput("pend blocks ready", wr_ready, 0);
    stepClk();
    runFill(320, "pending");

    applyStimulus(11'd639, 11'd525, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    applyStimulus(11'd640, 11'd525, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    runFill(0, "row0");
    applyStimulus(11'd7, 11'd0, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    checkOutput("row0 pix h7", pix_rgb, 12'h801);
    applyStimulus(11'd639, 11'd0, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    checkOutput("row0 pix h639", pix_rgb, 12'h89F);

    applyStimulus(11'd639, 11'd20, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk();
    applyStimulus(11'd640, 11'd20, 1'b0, 8'd0, 7'd0, 12'h000);
    stepClk(10);
    checkOutput("midfill busy", fill_busy, 1);
    rst = 1'b1;
    stepClk();
    checkOutput("abort busy", fill_busy, 0);
    applyStimulus(11'd641, 11'd20, 1'b0, 8'd0, 7'd0, 12'h000);
    rst = 1'b0;
    #1;
    stepClk();
    checkOutput("abort idle busy", fill_busy, 0);
    checkOutput("abort idle ready", wr_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
